// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// risc_toy_pkg
// Shared definitions for the RISC Toy memory port arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   MEM_LAT_DEF  : default memory read latency (cycles from m_cs to m_rdata)
//   AW_DEF/DW_DEF: default address / data widths
// -----------------------------------------------------------------------------
package risc_toy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int MEM_LAT_DEF = 2;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the data port, the memory port and the pipeline
// stall outputs of the arbiter.
//   slave  : arbiter side (takes requests and m_rdata, drives everything else)
//   master : environment side (pipeline stages + memory)
// Signals:
//   if_req/if_addr -> if_rdata/if_ready                 fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready        data port
//   m_cs/m_we/m_addr/m_wdata <- m_rdata                 memory port
//   stall_if/stall_mem                                  pipeline freeze
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import risc_toy_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          m_cs;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output m_cs, m_we, m_addr, m_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  m_cs, m_we, m_addr, m_wdata, stall_if, stall_mem
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the fetch stage and the MEM stage.
// One access at a time: grant in IDLE (data before fetch), hold the memory
// port for MEM_LAT+1 cycles with m_cs only in the first, capture m_rdata on
// the last, then pulse the matching ready for one cycle in DONE.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data, memory, stall signals)
// Parameters:
//   MEM_LAT : cycles from m_cs to valid m_rdata (1..15)
//   AW, DW  : address / data widths, must match the interface
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import risc_toy_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    mem_port_arbiter_if.slave bus
);

    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [CW-1:0] r_cnt;

    logic          r_m_cs;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_if_ready;
    logic          r_d_ready;

    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_acc_end;

    // Next-state logic. An access ends on the cycle its counter is zero,
    // which is MEM_LAT cycles after the m_cs cycle, i.e. when m_rdata is valid.
    always_comb begin
        w_state_next = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_acc_end    = 1'b0;
        case (r_state)
            IDLE: begin
                // The MEM-stage instruction is older, so it wins.
                if (bus.d_req) begin
                    w_state_next = ACC_D;
                    w_grant_d    = 1'b1;
                end else if (bus.if_req) begin
                    w_state_next = ACC_I;
                    w_grant_i    = 1'b1;
                end
            end
            ACC_I, ACC_D: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                    w_acc_end    = 1'b1;
                end
            end
            DONE: begin
                // Requests are not looked at here; a held request is picked
                // up in the IDLE cycle that follows.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_m_cs     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Chip select is a single pulse in the first access cycle.
            r_m_cs <= w_grant_d | w_grant_i;

            if (w_grant_d) begin
                r_m_we    <= bus.d_we;
                r_m_addr  <= bus.d_addr;
                r_m_wdata <= bus.d_wdata;
            end else if (w_grant_i) begin
                r_m_we   <= 1'b0;
                r_m_addr <= bus.if_addr;
            end

            if (w_grant_d || w_grant_i) begin
                r_cnt <= CNT_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end

            r_if_ready <= w_acc_end && (r_state == ACC_I);
            r_d_ready  <= w_acc_end && (r_state == ACC_D);

            if (w_acc_end && (r_state == ACC_I)) begin
                r_if_rdata <= bus.m_rdata;
            end
            // A store completes like a load but leaves the load data alone.
            if (w_acc_end && (r_state == ACC_D) && !r_m_we) begin
                r_d_rdata <= bus.m_rdata;
            end
        end
    end

    assign bus.m_cs     = r_m_cs;
    assign bus.m_we     = r_m_we;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.if_rdata = r_if_rdata;
    assign bus.if_ready = r_if_ready;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_ready  = r_d_ready;

    // The whole pipeline freezes for a data access; the front end also
    // freezes for its own fetch.
    assign bus.stall_mem = bus.d_req & ~r_d_ready;
    assign bus.stall_if  = (bus.if_req & ~r_if_ready) | bus.stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiters (MEM_LAT = 2, 1, 15) each with its own latency-accurate
// memory. Instance 0 runs directed scenarios against a transaction-level
// model; instances 1 and 2 measure request-to-ready latency.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int L0 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req_s   [3];
    logic [31:0] if_addr_s  [3];
    logic        d_req_s    [3];
    logic        d_we_s     [3];
    logic [31:0] d_addr_s   [3];
    logic [31:0] d_wdata_s  [3];
    logic [31:0] if_rdata_s [3];
    logic        if_ready_s [3];
    logic [31:0] d_rdata_s  [3];
    logic        d_ready_s  [3];
    logic        m_cs_s     [3];
    logic        m_we_s     [3];
    logic [31:0] m_addr_s   [3];
    logic [31:0] m_wdata_s  [3];
    logic        stall_if_s [3];
    logic        stall_mem_s[3];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEAD_BEEF;
        return 32'h5A5A_0000 | i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? L0 : (gi == 1) ? 1 : 15;

        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

        mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus)
        );

        assign bus.if_req      = if_req_s[gi];
        assign bus.if_addr     = if_addr_s[gi];
        assign bus.d_req       = d_req_s[gi];
        assign bus.d_we        = d_we_s[gi];
        assign bus.d_addr      = d_addr_s[gi];
        assign bus.d_wdata     = d_wdata_s[gi];
        assign if_rdata_s[gi]  = bus.if_rdata;
        assign if_ready_s[gi]  = bus.if_ready;
        assign d_rdata_s[gi]   = bus.d_rdata;
        assign d_ready_s[gi]   = bus.d_ready;
        assign m_cs_s[gi]      = bus.m_cs;
        assign m_we_s[gi]      = bus.m_we;
        assign m_addr_s[gi]    = bus.m_addr;
        assign m_wdata_s[gi]   = bus.m_wdata;
        assign stall_if_s[gi]  = bus.stall_if;
        assign stall_mem_s[gi] = bus.stall_mem;

        // Memory: read data valid only in the cycle LAT cycles after m_cs.
        logic [31:0] mem    [256];
        logic        pipe_v [16];
        logic [7:0]  pipe_a [16];

        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                for (int k = 0; k < 16; k++) begin
                    pipe_v[k] <= 1'b0;
                    pipe_a[k] <= 8'd0;
                end
            end else begin
                if (bus.m_cs && bus.m_we) mem[bus.m_addr[9:2]] <= bus.m_wdata;
                pipe_v[0] <= bus.m_cs & ~bus.m_we;
                pipe_a[0] <= bus.m_addr[9:2];
                for (int k = 1; k < 16; k++) begin
                    pipe_v[k] <= pipe_v[k-1];
                    pipe_a[k] <= pipe_a[k-1];
                end
            end
        end

        assign bus.m_rdata = (pipe_v[LAT-1] === 1'b1) ? mem[pipe_a[LAT-1]] : 32'hBAD0_0BAD;
    end

    // Transaction-level model of instance 0: a grant taken at the end of
    // cycle n puts m_cs in n+1, ready in n+L0+2, and the arbiter is free to
    // grant again at the end of cycle n+L0+3.
    initial begin : model
        int          n, t_cs, t_rdy, next_idle;
        bit          armed, kind_d, t_store;
        logic [31:0] t_val, e_addr, e_wdata, e_ird, e_drd;
        logic        e_we, e_cs, e_irdy, e_drdy, e_sm, e_si;
        logic [31:0] shadow [256];
        n = 0; t_cs = -1; t_rdy = -1; next_idle = 0;
        armed = 0; kind_d = 0; t_store = 0; t_val = '0;
        e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0; e_we = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clk);
            e_cs   = (n == t_cs);
            e_irdy = (n == t_rdy) && !kind_d;
            e_drdy = (n == t_rdy) && kind_d;
            if (e_irdy) e_ird = t_val;
            if (e_drdy && !t_store) e_drd = t_val;
            e_sm = d_req_s[0] & ~e_drdy;
            e_si = (if_req_s[0] & ~e_irdy) | e_sm;
            if (armed) begin
                chk("model_m_cs",      32'(m_cs_s[0]),      32'(e_cs));
                chk("model_m_we",      32'(m_we_s[0]),      32'(e_we));
                chk("model_m_addr",    m_addr_s[0],         e_addr);
                chk("model_m_wdata",   m_wdata_s[0],        e_wdata);
                chk("model_if_ready",  32'(if_ready_s[0]),  32'(e_irdy));
                chk("model_d_ready",   32'(d_ready_s[0]),   32'(e_drdy));
                chk("model_if_rdata",  if_rdata_s[0],       e_ird);
                chk("model_d_rdata",   d_rdata_s[0],        e_drd);
                chk("model_stall_if",  32'(stall_if_s[0]),  32'(e_si));
                chk("model_stall_mem", 32'(stall_mem_s[0]), 32'(e_sm));
            end
            if (rst) begin
                armed = 1; t_cs = -1; t_rdy = -1; next_idle = n + 1;
                e_addr = '0; e_wdata = '0; e_we = 1'b0; e_ird = '0; e_drd = '0;
                for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
            end else if (n >= next_idle) begin
                if (d_req_s[0]) begin
                    kind_d  = 1; t_store = d_we_s[0];
                    e_we    = d_we_s[0]; e_addr = d_addr_s[0]; e_wdata = d_wdata_s[0];
                    t_val   = shadow[d_addr_s[0][9:2]];
                    if (d_we_s[0]) shadow[d_addr_s[0][9:2]] = d_wdata_s[0];
                    t_cs = n + 1; t_rdy = n + L0 + 2; next_idle = n + L0 + 3;
                end else if (if_req_s[0]) begin
                    kind_d  = 0; t_store = 0;
                    e_we    = 1'b0; e_addr = if_addr_s[0];
                    t_val   = shadow[if_addr_s[0][9:2]];
                    t_cs = n + 1; t_rdy = n + L0 + 2; next_idle = n + L0 + 3;
                end
            end
            n++;
        end
    end

    // Results of the last run_txn, in cycles relative to the request cycle.
    int          r_ti, r_td, r_sif, r_smem, r_tcs;
    logic [31:0] r_acs, r_wdcs, r_rdi, r_rdd;
    logic        r_wecs;

    // Requests were set just after a rising edge (cycle 0); each is dropped
    // in the cycle after its ready pulse.
    task automatic run_txn(input string tag);
        bit drop_i, drop_d;
        r_ti = -1; r_td = -1; r_sif = 0; r_smem = 0; r_tcs = -1;
        r_acs = '0; r_wdcs = '0; r_wecs = 1'b0; r_rdi = '0; r_rdd = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall_if_s[0])  r_sif++;
            if (stall_mem_s[0]) r_smem++;
            if (m_cs_s[0] && r_tcs < 0) begin
                r_tcs = k; r_acs = m_addr_s[0]; r_wecs = m_we_s[0]; r_wdcs = m_wdata_s[0];
            end
            drop_i = 0; drop_d = 0;
            if (if_ready_s[0] && r_ti < 0) begin r_ti = k; r_rdi = if_rdata_s[0]; drop_i = 1; end
            if (d_ready_s[0]  && r_td < 0) begin r_td = k; r_rdd = d_rdata_s[0];  drop_d = 1; end
            @(posedge clk); #1;
            if (drop_i) if_req_s[0] = 1'b0;
            if (drop_d) d_req_s[0]  = 1'b0;
            if (!if_req_s[0] && !d_req_s[0]) break;
        end
        chk({tag, "_timeout"}, 32'(if_req_s[0] | d_req_s[0]), 32'd0);
        if_req_s[0] = 1'b0; d_req_s[0] = 1'b0; d_we_s[0] = 1'b0;
        $display("txn %s: cs@%0d addr=%h if_ready@%0d d_ready@%0d if_rdata=%h d_rdata=%h",
                 tag, r_tcs, r_acs, r_ti, r_td, r_rdi, r_rdd);
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int w, input int exp_lat);
        int          lat;
        logic [31:0] rd;
        lat = -1; rd = '0;
        if_addr_s[w] = 32'h100; if_req_s[w] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_ready_s[w]) begin lat = k; rd = if_rdata_s[w]; break; end
        end
        @(posedge clk); #1;
        if_req_s[w] = 1'b0;
        chk($sformatf("sweep%0d_latency", w), 32'(lat), 32'(exp_lat));
        chk($sformatf("sweep%0d_rdata", w), rd, 32'hDEAD_BEEF);
        $display("txn sweep inst=%0d latency=%0d rdata=%h", w, lat, rd);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0, c1, q0, q1, rdy_cnt;
        logic [31:0] rd1;
        for (int i = 0; i < 3; i++) begin
            if_req_s[i] = 1'b0; if_addr_s[i] = '0; d_req_s[i] = 1'b0;
            d_we_s[i] = 1'b0; d_addr_s[i] = '0; d_wdata_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Reset state, idle outputs.
        chk("rst_m_cs",      32'(m_cs_s[0]),      32'd0);
        chk("rst_m_we",      32'(m_we_s[0]),      32'd0);
        chk("rst_m_addr",    m_addr_s[0],         32'd0);
        chk("rst_m_wdata",   m_wdata_s[0],        32'd0);
        chk("rst_if_rdata",  if_rdata_s[0],       32'd0);
        chk("rst_d_rdata",   d_rdata_s[0],        32'd0);
        chk("rst_if_ready",  32'(if_ready_s[0]),  32'd0);
        chk("rst_d_ready",   32'(d_ready_s[0]),   32'd0);
        chk("rst_stall_if",  32'(stall_if_s[0]),  32'd0);
        chk("rst_stall_mem", 32'(stall_mem_s[0]), 32'd0);

        // Fetch only.
        if_addr_s[0] = 32'h100; if_req_s[0] = 1'b1;
        run_txn("fetch");
        chk("fetch_cs_cycle",  32'(r_tcs),  32'd1);
        chk("fetch_cs_addr",   r_acs,       32'h100);
        chk("fetch_ready_cyc", 32'(r_ti),   32'd4);
        chk("fetch_rdata",     r_rdi,       32'hDEAD_BEEF);
        chk("fetch_stall_if",  32'(r_sif),  32'd4);
        chk("fetch_stall_mem", 32'(r_smem), 32'd0);
        idle(2);

        // Simultaneous load and fetch: load first.
        d_addr_s[0] = 32'h200; d_we_s[0] = 1'b0; d_req_s[0] = 1'b1;
        if_addr_s[0] = 32'h104; if_req_s[0] = 1'b1;
        run_txn("load+fetch");
        chk("both_cs_addr",   r_acs,       32'h200);
        chk("both_d_ready",   32'(r_td),   32'd4);
        chk("both_if_ready",  32'(r_ti),   32'd9);
        chk("both_d_rdata",   r_rdd,       32'h5A5A_0080);
        chk("both_if_rdata",  r_rdi,       32'h5A5A_0041);
        chk("both_stall_mem", 32'(r_smem), 32'd4);
        chk("both_stall_if",  32'(r_sif),  32'd9);
        idle(2);

        // Store.
        d_addr_s[0] = 32'h300; d_wdata_s[0] = 32'h1234_5678; d_we_s[0] = 1'b1; d_req_s[0] = 1'b1;
        run_txn("store");
        chk("store_cs_cycle", 32'(r_tcs), 32'd1);
        chk("store_cs_addr",  r_acs,      32'h300);
        chk("store_cs_we",    32'(r_wecs), 32'd1);
        chk("store_wdata",    r_wdcs,     32'h1234_5678);
        chk("store_ready",    32'(r_td),  32'd4);
        chk("store_d_rdata",  r_rdd,      32'h5A5A_0080);
        idle(2);

        // Load back what was stored.
        d_addr_s[0] = 32'h300; d_we_s[0] = 1'b0; d_req_s[0] = 1'b1;
        run_txn("loadback");
        chk("loadback_rdata", r_rdd, 32'h1234_5678);
        idle(2);

        // Back-to-back fetches with the request held across DONE.
        c0 = -1; c1 = -1; q0 = -1; q1 = -1; rd1 = '0;
        if_addr_s[0] = 32'h100; if_req_s[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_cs_s[0]) begin if (c0 < 0) c0 = k; else if (c1 < 0) c1 = k; end
            if (if_ready_s[0]) begin
                if (q0 < 0) q0 = k;
                else if (q1 < 0) begin q1 = k; rd1 = if_rdata_s[0]; end
            end
            @(posedge clk); #1;
            if (q0 == k) if_addr_s[0] = 32'h104;
            if (q1 == k) begin if_req_s[0] = 1'b0; break; end
        end
        if_req_s[0] = 1'b0;
        chk("b2b_cs0",    32'(c0), 32'd1);
        chk("b2b_cs1",    32'(c1), 32'd6);
        chk("b2b_rdy0",   32'(q0), 32'd4);
        chk("b2b_rdy1",   32'(q1), 32'd9);
        chk("b2b_rdata1", rd1,     32'h5A5A_0041);
        $display("txn back2back: cs@%0d,%0d ready@%0d,%0d rdata=%h", c0, c1, q0, q1, rd1);
        idle(2);

        // Reset in the middle of a load.
        d_addr_s[0] = 32'h200; d_we_s[0] = 1'b0; d_req_s[0] = 1'b1;
        idle(2);
        rst = 1'b1; d_req_s[0] = 1'b0;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_m_cs",     32'(m_cs_s[0]),     32'd0);
        chk("mrst_m_addr",   m_addr_s[0],        32'd0);
        chk("mrst_d_ready",  32'(d_ready_s[0]),  32'd0);
        chk("mrst_d_rdata",  d_rdata_s[0],       32'd0);
        chk("mrst_if_rdata", if_rdata_s[0],      32'd0);
        chk("mrst_stall_if", 32'(stall_if_s[0]), 32'd0);
        rdy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_ready_s[0] || if_ready_s[0]) rdy_cnt++;
        end
        chk("mrst_no_ready", 32'(rdy_cnt), 32'd0);
        $display("txn midreset: ready pulses after reset=%0d", rdy_cnt);
        @(posedge clk); #1;

        if_addr_s[0] = 32'h104; if_req_s[0] = 1'b1;
        run_txn("post_reset_fetch");
        chk("post_rst_ready", 32'(r_ti), 32'd4);
        chk("post_rst_rdata", r_rdi,     32'h5A5A_0041);
        idle(2);

        // Latency sweep on the other two instances.
        sweep(1, 3);
        sweep(2, 17);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory of the pipelined RISC Toy core between the fetch stage (IF) and the memory stage (MEM). It serialises accesses, waits out a fixed memory latency, and returns read data with a one-cycle ready pulse. While a request is outstanding it drives the stall signals that freeze the PC and the IF_ID/ID_EX/EX_MEM/MEM_WB registers. When MEM_WB is frozen it inserts a bubble with cleared WB control.

## Interface
Parameters:
- MEM_LAT, 2, memory read latency in cycles from the m_cs cycle to valid m_rdata; legal range 1..15
- AW, 32, address width
- DW, 32, data width

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  fetched instruction; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  MEM-stage load/store request; held high until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- m_cs  out  1  memory chip select, one cycle per access
- m_we  out  1  memory write enable, qualified by m_cs
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_cs
- stall_if  out  1  freezes PC and IF_ID
- stall_mem  out  1  freezes the whole pipeline and forces the MEM_WB bubble

## Operation
- FSM states: IDLE, ACC_I, ACC_D, DONE.
- IDLE:
  - d_req=1 → ACC_D; latch d_addr/d_we/d_wdata into the m_* registers; m_cs=1 next cycle.
  - else if_req=1 → ACC_I; latch if_addr; m_we=0.
  - Data has fixed priority over fetch because it belongs to the older instruction.
- ACC_I/ACC_D:
  - Latency counter cnt (width $clog2(MEM_LAT+1)) loads MEM_LAT on entry and decrements each cycle.
  - m_cs=1 only in the first ACC cycle; m_we/m_addr/m_wdata hold for the whole state.
  - When cnt reaches 0, capture m_rdata into the if_rdata or d_rdata register and go to DONE.
- DONE: pulse the matching ready for exactly one cycle. Requests are ignored in DONE. Next state is IDLE.
- Stores: d_ready pulses with the same timing as loads; d_rdata is unchanged.
- Stalls (combinational from registered state):
  - stall_mem = d_req & ~d_ready
  - stall_if = (if_req & ~if_ready) | stall_mem
- If a requester drops its request mid-access, the access still completes and its ready still pulses. No abort.
- Reset values: state=IDLE, cnt=0, m_cs=0, m_we=0, m_addr=0, m_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0.
- RST asserted mid-access: the next edge forces the reset values and the in-flight result is discarded. RST has priority over all other inputs.

## Timing
- Request sampled high at edge t (IDLE) → m_cs high in cycle t+1 → m_rdata captured at edge t+1+MEM_LAT → ready high in cycle t+1+MEM_LAT+1.
- Total request-to-ready latency is MEM_LAT+2 cycles; MEM_LAT=2 gives 4.
- Back-to-back: a request held after DONE is granted at the IDLE edge that follows. Minimum spacing between two m_cs pulses is MEM_LAT+3 cycles.
- Simultaneous if_req and d_req in IDLE: data is served first. Fetch is granted in the IDLE cycle after the data DONE, with stall_if held throughout.
- A request that arrives while another access is active waits; its stall stays asserted.

## Structure
- Shared package risc_toy_pkg holds:
  - arb_state_t enum (IDLE, ACC_I, ACC_D, DONE)
  - MEM_LAT default constant
  - AW/DW defaults
- A single module is sufficient. The latency counter stays inline, with no sub-module.

## Test plan
- Reset, then idle: all outputs 0; stall_if=stall_mem=0 with no requests.
- Fetch only, if_addr=0x100, memory returns 0xDEADBEEF, MEM_LAT=2:
  - m_cs=1 with m_addr=0x100 one cycle after the request
  - if_ready=1 and if_rdata=0xDEADBEEF exactly 4 cycles after the request
  - stall_if=1 in the intervening cycles
- Simultaneous d_req (load 0x200) and if_req (0x104):
  - load served first; d_ready at cycle +4
  - fetch m_cs follows; if_ready at cycle +9
  - stall_mem=1 until d_ready; stall_if=1 until if_ready
- Store d_we=1, addr 0x300, data 0x12345678:
  - m_we=m_cs=1 with m_wdata=0x12345678
  - d_ready at +4; d_rdata unchanged
- RST pulsed during ACC_D: next cycle state is IDLE, all outputs 0, no ready pulse; a subsequent request completes normally.
- Sweep MEM_LAT=1 and 15: request-to-ready latency is 3 and 17 cycles respectively.
